calc_entrada_teclado: RTL

- Operand/operator entry controller for the calculator: the producer side of the result display mux.
- Consumes debounced key events and assembles two BCD operands into reg_A and reg_B.
- Latches the operation code and drives the 2-bit estado sequence the display and arithmetic units key off.
- Issues a one-cycle start pulse to the arithmetic units, then waits for DONE.

---
 rtl/calc_pkg.sv | 42 ++++
 rtl/bcd_acumulador.sv | 50 +++++
 rtl/calc_entrada_teclado.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator key-entry path: key codes, operation and state encodings.
package calc_pkg;

  localparam int DIGITOS_DEF = 10;

  localparam logic [4:0] TECLA_MAX_DIGITO = 5'd9;
  localparam logic [4:0] TECLA_SUMA       = 5'd16;
  localparam logic [4:0] TECLA_RESTA      = 5'd17;
  localparam logic [4:0] TECLA_MULT       = 5'd18;
  localparam logic [4:0] TECLA_DIV        = 5'd19;
  localparam logic [4:0] TECLA_RAIZ       = 5'd20;
  localparam logic [4:0] TECLA_IGUAL      = 5'd21;
  localparam logic [4:0] TECLA_BORRAR     = 5'd22;

  typedef enum logic [1:0] {
    EST_IDLE  = 2'b00,
    EST_ENT_A = 2'b01,
    EST_ENT_B = 2'b10,
    EST_CALC  = 2'b11
  } estado_e;

  typedef enum logic [2:0] {
    OP_SUMA  = 3'b000,
    OP_RESTA = 3'b001,
    OP_MULT  = 3'b010,
    OP_DIV   = 3'b011,
    OP_RAIZ  = 3'b100
  } op_e;

  function automatic op_e op_de_tecla(input logic [4:0] t);
    op_e r;
    case (t)
      TECLA_RESTA: r = OP_RESTA;
      TECLA_MULT:  r = OP_MULT;
      TECLA_DIV:   r = OP_DIV;
      TECLA_RAIZ:  r = OP_RAIZ;
      default:     r = OP_SUMA;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_acumulador.sv
// Packed-BCD operand register with a digit counter that ignores leading zeros.
module bcd_acumulador #(
  parameter int DIGITOS = 10,
  parameter int W       = 4 * DIGITOS,
  parameter int CW      = $clog2(DIGITOS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          shift,
  input  logic [3:0]    digito,
  output logic [W-1:0]  valor,
  output logic [CW-1:0] cuenta
);

  logic [W-1:0]  valor_q, valor_d;
  logic [CW-1:0] cuenta_q, cuenta_d;

  always_comb begin
    valor_d  = valor_q;
    cuenta_d = cuenta_q;
    if (clear) begin
      valor_d  = '0;
      cuenta_d = '0;
    end else if (load) begin
      valor_d  = {{(W-4){1'b0}}, digito};
      cuenta_d = (digito != 4'd0) ? CW'(1) : '0;
    end else if (shift && (cuenta_q != CW'(DIGITOS))) begin
      valor_d = {valor_q[W-5:0], digito};
      // A zero shifted into an all-zero register is a leading zero
      if ((valor_q != '0) || (digito != 4'd0))
        cuenta_d = cuenta_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valor_q  <= '0;
      cuenta_q <= '0;
    end else begin
      valor_q  <= valor_d;
      cuenta_q <= cuenta_d;
    end
  end

  assign valor  = valor_q;
  assign cuenta = cuenta_q;

endmodule

// File: rtl/calc_entrada_teclado.sv
// Key-entry controller: builds operands A and B, latches the operation, and
// hands off to the arithmetic units with a one-cycle inicio pulse.
module calc_entrada_teclado
  import calc_pkg::*;
#(
  parameter int DIGITOS = DIGITOS_DEF,
  parameter int W       = 4 * DIGITOS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tecla_valida,
  input  logic [4:0]   tecla,
  input  logic         DONE,
  output logic [W-1:0] reg_A,
  output logic [W-1:0] reg_B,
  output logic [1:0]   estado,
  output logic [2:0]   OP,
  output logic         inicio,
  output logic         listo
);

  localparam int CW = $clog2(DIGITOS + 1);

  estado_e estado_q, estado_d;
  op_e     op_q, op_d;
  logic    inicio_q, inicio_d;
  logic    listo_q, listo_d;

  logic clr_a, ld_a, sh_a;
  logic clr_b, sh_b;
  logic [CW-1:0] cuenta_a, cuenta_b;

  logic es_digito, es_oper, es_raiz, es_igual, es_borrar;

  assign es_digito = tecla_valida && (tecla <= TECLA_MAX_DIGITO);
  assign es_oper   = tecla_valida && (tecla >= TECLA_SUMA) && (tecla <= TECLA_DIV);
  assign es_raiz   = tecla_valida && (tecla == TECLA_RAIZ);
  assign es_igual  = tecla_valida && (tecla == TECLA_IGUAL);
  assign es_borrar = tecla_valida && (tecla == TECLA_BORRAR);

  always_ff @(posedge clk) begin
    if (rst) estado_q <= EST_IDLE;
    else     estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    if (es_borrar) begin
      estado_d = EST_IDLE;
    end else begin
      case (estado_q)
        EST_IDLE:  if (es_digito) estado_d = EST_ENT_A;
        EST_ENT_A: begin
          if (es_oper)      estado_d = EST_ENT_B;
          else if (es_raiz) estado_d = EST_CALC;
        end
        EST_ENT_B: if (es_igual && (cuenta_b != '0)) estado_d = EST_CALC;
        EST_CALC:  if (listo_q && es_digito) estado_d = EST_ENT_A;
        default:   estado_d = EST_IDLE;
      endcase
    end
  end

  always_comb begin
    clr_a    = 1'b0;
    ld_a     = 1'b0;
    sh_a     = 1'b0;
    clr_b    = 1'b0;
    sh_b     = 1'b0;
    op_d     = op_q;
    inicio_d = 1'b0;
    listo_d  = listo_q;
    if (es_borrar) begin
      clr_a   = 1'b1;
      clr_b   = 1'b1;
      op_d    = OP_SUMA;
      listo_d = 1'b0;
    end else begin
      case (estado_q)
        EST_IDLE: ld_a = es_digito;
        EST_ENT_A: begin
          if (es_digito) begin
            sh_a = 1'b1;
          end else if (es_oper) begin
            op_d  = op_de_tecla(tecla);
            clr_b = 1'b1;
          end else if (es_raiz) begin
            op_d     = OP_RAIZ;
            inicio_d = 1'b1;
          end
        end
        EST_ENT_B: begin
          if (es_digito) begin
            sh_b = 1'b1;
          end else if (es_oper) begin
            op_d = op_de_tecla(tecla);
          end else if (es_igual && (cuenta_b != '0)) begin
            inicio_d = 1'b1;
          end
        end
        EST_CALC: begin
          if (listo_q && es_digito) begin
            ld_a    = 1'b1;
            clr_b   = 1'b1;
            listo_d = 1'b0;
          end else if (DONE && !inicio_q) begin
            // DONE during the inicio cycle cannot belong to this operation
            listo_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_SUMA;
      inicio_q <= 1'b0;
      listo_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      inicio_q <= inicio_d;
      listo_q  <= listo_d;
    end
  end

  bcd_acumulador #(.DIGITOS(DIGITOS), .W(W), .CW(CW)) u_acc_a (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_a),
    .load   (ld_a),
    .shift  (sh_a),
    .digito (tecla[3:0]),
    .valor  (reg_A),
    .cuenta (cuenta_a)
  );

  bcd_acumulador #(.DIGITOS(DIGITOS), .W(W), .CW(CW)) u_acc_b (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_b),
    .load   (1'b0),
    .shift  (sh_b),
    .digito (tecla[3:0]),
    .valor  (reg_B),
    .cuenta (cuenta_b)
  );

  assign estado = estado_q;
  assign OP     = op_q;
  assign inicio = inicio_q;
  assign listo  = listo_q;

endmodule
